// File: rtl/square_game_core.sv
`timescale 1ns/1ps
// square_game_core
// Game state for a dodge-the-squares game on a 640x480 raster: a player
// square steered by four buttons, up to NUM_SQ bouncing enemy squares that
// are activated one by one over time, a frame score, and the pixel colour
// for the current raster position.
//
// Ports
//   clk_100MHz    system clock, all state on its rising edge
//   reset         asynchronous, active-low; clears every register
//   refresh_tick  one-cycle pulse per frame, advances the game
//   p_tick        pixel strobe, registers rgb for pixel (x,y)
//   video_on      raster is inside the active area
//   x, y          current pixel coordinates
//   btnU/L/D/R    debounced direction buttons
//   start         IDLE->PLAY and OVER->IDLE
//   rgb           12-bit pixel colour, registered on p_tick
//   status        0 IDLE, 1 PLAY, 2 OVER
//   score         non-colliding PLAY frames, saturating
//   active_cnt    number of enemies currently in play
//
// state | meaning
// IDLE  | waiting for start, positions frozen
// PLAY  | game running, advances on refresh_tick
// OVER  | collision happened, frozen until start
module square_game_core #(
  parameter int NUM_SQ       = 8,
  parameter int SQ_SIZE      = 16,
  parameter int PL_SIZE      = 32,
  parameter int PL_STEP      = 4,
  parameter int SQ_STEP      = 2,
  parameter int SPAWN_FRAMES = 120
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        refresh_tick,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btnU,
  input  logic        btnL,
  input  logic        btnD,
  input  logic        btnR,
  input  logic        start,
  output logic [11:0] rgb,
  output logic [1:0]  status,
  output logic [15:0] score,
  output logic [4:0]  active_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  // All geometry is done in 11 bits so that "position + size" and the
  // edge tests never wrap.
  localparam logic [10:0] PLS      = 11'(PL_SIZE);
  localparam logic [10:0] SQS      = 11'(SQ_SIZE);
  localparam logic [10:0] PST      = 11'(PL_STEP);
  localparam logic [10:0] SST      = 11'(SQ_STEP);
  localparam logic [10:0] PL_X_MAX = 11'(640 - PL_SIZE);
  localparam logic [10:0] PL_Y_MAX = 11'(480 - PL_SIZE);
  localparam logic [10:0] SQ_X_MAX = 11'(640 - SQ_SIZE);
  localparam logic [10:0] SQ_Y_MAX = 11'(480 - SQ_SIZE);
  localparam int          SPW      = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam logic [SPW-1:0] SPAWN_LAST = SPW'(SPAWN_FRAMES - 1);
  localparam logic [4:0]  ACT_MAX  = 5'(NUM_SQ);

  state_t              state_q, state_d;
  logic [9:0]          pl_x_q, pl_x_d, pl_y_q, pl_y_d;
  logic [9:0]          en_x_q [NUM_SQ];
  logic [9:0]          en_x_d [NUM_SQ];
  logic [9:0]          en_y_q [NUM_SQ];
  logic [9:0]          en_y_d [NUM_SQ];
  logic [NUM_SQ-1:0]   en_dx_q, en_dx_d;   // 1 = moving toward +x
  logic [NUM_SQ-1:0]   en_dy_q, en_dy_d;   // 1 = moving toward +y
  logic [15:0]         score_q, score_d;
  logic [4:0]          active_q, active_d;
  logic [SPW-1:0]      spawn_q, spawn_d;
  logic [11:0]         rgb_q, rgb_d;

  logic                coll;
  logic [10:0]         px, py, ex, ey;
  logic [10:0]         xw, yw;
  logic                pl_hit, en_hit;
  logic [11:0]         bg;

  // Overlap of the player with any active enemy, on registered positions.
  always_comb begin
    coll = 1'b0;
    for (int i = 0; i < NUM_SQ; i++) begin
      if ((5'(i) < active_q) &&
          ({1'b0, en_x_q[i]} < {1'b0, pl_x_q} + PLS) &&
          ({1'b0, pl_x_q} < {1'b0, en_x_q[i]} + SQS) &&
          ({1'b0, en_y_q[i]} < {1'b0, pl_y_q} + PLS) &&
          ({1'b0, pl_y_q} < {1'b0, en_y_q[i]} + SQS)) begin
        coll = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pl_x_d   = pl_x_q;
    pl_y_d   = pl_y_q;
    en_x_d   = en_x_q;
    en_y_d   = en_y_q;
    en_dx_d  = en_dx_q;
    en_dy_d  = en_dy_q;
    score_d  = score_q;
    active_d = active_q;
    spawn_d  = spawn_q;
    px       = {1'b0, pl_x_q};
    py       = {1'b0, pl_y_q};
    ex       = '0;
    ey       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PLAY;
          pl_x_d   = 10'd304;
          pl_y_d   = 10'd224;
          score_d  = '0;
          active_d = 5'd1;
          spawn_d  = '0;
          en_dx_d  = '1;
          en_dy_d  = '1;
          for (int i = 0; i < NUM_SQ; i++) begin
            en_x_d[i] = 10'((i * 40) % (640 - SQ_SIZE));
            en_y_d[i] = '0;
          end
        end
      end

      S_PLAY: begin
        if (refresh_tick) begin
          if (coll) begin
            state_d = S_OVER;
          end else begin
            // Opposing buttons on one axis cancel; the low-side tests
            // compare before subtracting so nothing underflows.
            if (btnR && !btnL)
              px = (px + PST >= PL_X_MAX) ? PL_X_MAX : px + PST;
            else if (btnL && !btnR)
              px = (px <= PST) ? 11'd0 : px - PST;
            if (btnD && !btnU)
              py = (py + PST >= PL_Y_MAX) ? PL_Y_MAX : py + PST;
            else if (btnU && !btnD)
              py = (py <= PST) ? 11'd0 : py - PST;
            pl_x_d = px[9:0];
            pl_y_d = py[9:0];

            // Reaching an edge counts as crossing it: clamp and bounce
            // in the same frame.
            for (int i = 0; i < NUM_SQ; i++) begin
              if (5'(i) < active_q) begin
                ex = {1'b0, en_x_q[i]};
                ey = {1'b0, en_y_q[i]};
                if (en_dx_q[i]) begin
                  if (ex + SST >= SQ_X_MAX) begin
                    ex = SQ_X_MAX;
                    en_dx_d[i] = 1'b0;
                  end else ex = ex + SST;
                end else begin
                  if (ex <= SST) begin
                    ex = 11'd0;
                    en_dx_d[i] = 1'b1;
                  end else ex = ex - SST;
                end
                if (en_dy_q[i]) begin
                  if (ey + SST >= SQ_Y_MAX) begin
                    ey = SQ_Y_MAX;
                    en_dy_d[i] = 1'b0;
                  end else ey = ey + SST;
                end else begin
                  if (ey <= SST) begin
                    ey = 11'd0;
                    en_dy_d[i] = 1'b1;
                  end else ey = ey - SST;
                end
                en_x_d[i] = ex[9:0];
                en_y_d[i] = ey[9:0];
              end
            end

            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;

            if (spawn_q == SPAWN_LAST) begin
              spawn_d = '0;
              if (active_q < ACT_MAX) active_d = active_q + 5'd1;
            end else begin
              spawn_d = spawn_q + SPW'(1);
            end
          end
        end
      end

      S_OVER: begin
        if (start) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    xw     = {1'b0, x};
    yw     = {1'b0, y};
    pl_hit = (xw >= {1'b0, pl_x_q}) && (xw < {1'b0, pl_x_q} + PLS) &&
             (yw >= {1'b0, pl_y_q}) && (yw < {1'b0, pl_y_q} + PLS);
    en_hit = 1'b0;
    for (int i = 0; i < NUM_SQ; i++) begin
      if ((5'(i) < active_q) &&
          (xw >= {1'b0, en_x_q[i]}) && (xw < {1'b0, en_x_q[i]} + SQS) &&
          (yw >= {1'b0, en_y_q[i]}) && (yw < {1'b0, en_y_q[i]} + SQS)) begin
        en_hit = 1'b1;
      end
    end
    bg    = (state_q == S_OVER) ? 12'h400 : 12'h222;
    rgb_d = rgb_q;
    if (p_tick) begin
      if (!video_on)   rgb_d = 12'h000;
      else if (pl_hit) rgb_d = 12'h0F0;
      else if (en_hit) rgb_d = 12'hF00;
      else             rgb_d = bg;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pl_x_q   <= '0;
      pl_y_q   <= '0;
      en_dx_q  <= '0;
      en_dy_q  <= '0;
      score_q  <= '0;
      active_q <= '0;
      spawn_q  <= '0;
      rgb_q    <= '0;
      for (int i = 0; i < NUM_SQ; i++) begin
        en_x_q[i] <= '0;
        en_y_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pl_x_q   <= pl_x_d;
      pl_y_q   <= pl_y_d;
      en_dx_q  <= en_dx_d;
      en_dy_q  <= en_dy_d;
      score_q  <= score_d;
      active_q <= active_d;
      spawn_q  <= spawn_d;
      rgb_q    <= rgb_d;
      for (int i = 0; i < NUM_SQ; i++) begin
        en_x_q[i] <= en_x_d[i];
        en_y_q[i] <= en_y_d[i];
      end
    end
  end

  assign rgb        = rgb_q;
  assign status     = state_q;
  assign score      = score_q;
  assign active_cnt = active_q;

endmodule

// File: tb/tb_square_game_core.sv
`timescale 1ns/1ps
module tb_square_game_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, p_tick, video_on;
  logic [9:0]  px, py;
  logic        b_u, b_l, b_d, b_r;
  logic        start_a, start_b, rt_a, rt_b;
  logic [11:0] rgb_a, rgb_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] sc_a, sc_b;
  logic [4:0]  ac_a, ac_b;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  // Default parameters.
  square_game_core dut_a (
    .clk_100MHz(clk), .reset(rst_n), .refresh_tick(rt_a), .p_tick(p_tick),
    .video_on(video_on), .x(px), .y(py),
    .btnU(b_u), .btnL(b_l), .btnD(b_d), .btnR(b_r), .start(start_a),
    .rgb(rgb_a), .status(st_a), .score(sc_a), .active_cnt(ac_a)
  );

  // Fast spawning, three enemies.
  square_game_core #(.NUM_SQ(3), .SPAWN_FRAMES(4)) dut_b (
    .clk_100MHz(clk), .reset(rst_n), .refresh_tick(rt_b), .p_tick(p_tick),
    .video_on(video_on), .x(px), .y(py),
    .btnU(b_u), .btnL(b_l), .btnD(b_d), .btnR(b_r), .start(start_b),
    .rgb(rgb_b), .status(st_b), .score(sc_b), .active_cnt(ac_b)
  );

  task automatic expect_val(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(tag, e);
    check_next(obs);
  endtask

  // Pixel probe: expectation queued when p_tick is driven, compared one
  // clock later when rgb has been registered.
  task automatic probe(input bit sel_b, input string tag, input int xx, input int yy,
                       input logic v, input logic [11:0] e);
    px = 10'(xx); py = 10'(yy); video_on = v; p_tick = 1'b1;
    expect_val(tag, 32'(e));
    @(posedge clk); #1;
    p_tick = 1'b0;
    check_next(sel_b ? 32'(rgb_b) : 32'(rgb_a));
  endtask

  task automatic frame_a(input int n);
    repeat (n) begin
      rt_a = 1'b1;
      @(posedge clk); #1;
      rt_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_b(input int n);
    repeat (n) begin
      rt_b = 1'b1;
      @(posedge clk); #1;
      rt_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; p_tick = 1'b0; video_on = 1'b1; px = '0; py = '0;
    b_u = 1'b0; b_l = 1'b0; b_d = 1'b0; b_r = 1'b0;
    start_a = 1'b0; start_b = 1'b0; rt_a = 1'b0; rt_b = 1'b0;

    // Reset holds everything at zero, even with pixel strobes present.
    repeat (2) @(posedge clk);
    #1;
    p_tick = 1'b1; px = 10'd10; py = 10'd10;
    @(posedge clk); #1;
    p_tick = 1'b0;
    chk("rst_status", 32'(st_a), 32'd0);
    chk("rst_score", 32'(sc_a), 32'd0);
    chk("rst_active", 32'(ac_a), 32'd0);
    chk("rst_rgb", 32'(rgb_a), 32'h000);

    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_rst", 32'(st_a), 32'd0);

    // ---- instance B: spawning and natural collision ----
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("b_start_status", 32'(st_b), 32'd1);
    chk("b_start_active", 32'(ac_b), 32'd1);
    for (int f = 1; f <= 20; f++) begin
      expect_val("b_active_cnt", (f < 4) ? 32'd1 : (f < 8) ? 32'd2 : 32'd3);
      frame_b(1);
      check_next(32'(ac_b));
    end
    chk("b_score20", 32'(sc_b), 32'd20);

    // Enemy 2 starts moving after frame 8 from (80,0) and first overlaps the
    // stationary player at (290,210) after frame 113; frame 114 ends the game.
    for (int k = 0; k < 300 && st_b != 2'd2; k++) frame_b(1);
    chk("b_over_status", 32'(st_b), 32'd2);
    chk("b_over_score", 32'(sc_b), 32'd113);
    frame_b(2);
    chk("b_over_frozen", 32'(sc_b), 32'd113);
    probe(1'b1, "b_over_bg", 600, 400, 1'b1, 12'h400);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("b_over_to_idle", 32'(st_b), 32'd0);
    probe(1'b1, "b_idle_bg", 600, 400, 1'b1, 12'h222);

    // ---- instance A: movement, clamping, enemy bounce ----
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("a_start_status", 32'(st_a), 32'd1);
    chk("a_start_score", 32'(sc_a), 32'd0);
    chk("a_start_active", 32'(ac_a), 32'd1);
    probe(1'b0, "a_pl_topleft", 304, 224, 1'b1, 12'h0F0);
    probe(1'b0, "a_pl_left_out", 303, 224, 1'b1, 12'h222);
    probe(1'b0, "a_pl_botright", 335, 255, 1'b1, 12'h0F0);
    probe(1'b0, "a_pl_right_out", 336, 255, 1'b1, 12'h222);
    probe(1'b0, "a_pl_below_out", 304, 256, 1'b1, 12'h222);
    probe(1'b0, "a_en0_pixel", 1, 1, 1'b1, 12'hF00);
    probe(1'b0, "a_en1_inactive", 41, 1, 1'b1, 12'h222);
    probe(1'b0, "a_pl_video_on", 310, 230, 1'b1, 12'h0F0);
    px = 10'd600; py = 10'd400;
    @(posedge clk); #1;
    chk("a_rgb_holds", 32'(rgb_a), 32'h0F0);
    probe(1'b0, "a_video_off", 310, 230, 1'b0, 12'h000);

    b_r = 1'b1;
    frame_a(100);
    b_r = 1'b0;
    chk("a_score100", 32'(sc_a), 32'd100);
    chk("a_active100", 32'(ac_a), 32'd1);
    probe(1'b0, "a_pl_xmax_in", 608, 224, 1'b1, 12'h0F0);
    probe(1'b0, "a_pl_xmax_out", 607, 224, 1'b1, 12'h222);
    probe(1'b0, "a_pl_xmax_edge", 639, 255, 1'b1, 12'h0F0);

    b_l = 1'b1; b_r = 1'b1;
    frame_a(10);
    b_l = 1'b0; b_r = 1'b0;
    probe(1'b0, "a_lr_hold_in", 608, 224, 1'b1, 12'h0F0);
    probe(1'b0, "a_lr_hold_out", 607, 224, 1'b1, 12'h222);

    frame_a(122);
    chk("a_play232", 32'(st_a), 32'd1);
    chk("a_score232", 32'(sc_a), 32'd232);
    chk("a_active232", 32'(ac_a), 32'd2);
    probe(1'b0, "a_en0_bottom", 464, 464, 1'b1, 12'hF00);
    probe(1'b0, "a_en0_bottom_edge", 479, 479, 1'b1, 12'hF00);
    probe(1'b0, "a_en0_above", 464, 463, 1'b1, 12'h222);
    frame_a(1);
    probe(1'b0, "a_en0_bounced", 466, 462, 1'b1, 12'hF00);
    probe(1'b0, "a_en0_bounced_above", 466, 461, 1'b1, 12'h222);
    probe(1'b0, "a_en0_bounced_left", 465, 462, 1'b1, 12'h222);

    // Reset mid-game aborts at once, without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("a_midrst_status", 32'(st_a), 32'd0);
    chk("a_midrst_score", 32'(sc_a), 32'd0);
    chk("a_midrst_active", 32'(ac_a), 32'd0);
    chk("a_midrst_rgb", 32'(rgb_a), 32'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("a_postrst_idle", 32'(st_a), 32'd0);

    // Start wins over a simultaneous refresh_tick; that frame does nothing.
    start_a = 1'b1; rt_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; rt_a = 1'b0;
    chk("a_restart_status", 32'(st_a), 32'd1);
    chk("a_restart_score", 32'(sc_a), 32'd0);
    frame_a(1);
    chk("a_restart_score1", 32'(sc_a), 32'd1);
    probe(1'b0, "a_restart_player", 304, 224, 1'b1, 12'h0F0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
